hazard_pool_array: RTL and testbench
====================================

Name: hazard_pool_array

Overview:
- Parametrised successor to the fixed three-pool water/lava hazard logic.
- Holds a runtime-loadable table of POOL_COUNT rectangular hazard pools, each with a per-player immunity mask.
- Once per frame, scans the table sequentially (one pool per clock, one shared comparator set per player) against latched player bounding boxes. Raises sticky per-player death flags after a configurable number of consecutive hit frames.
- Sits between the player physics blocks and the game-state FSM.

Parameters:
- POOL_COUNT, 4, number of pool table entries (≥1).
- PLAYER_COUNT, 2, number of players checked (≥1).
- COORD_W, 16, signed coordinate width (matches shortint).
- POOL_W, 74, pool width in pixels.
- POOL_H, 5, pool height in pixels.
- GRACE_FRAMES, 1, consecutive hit frames required to kill (≥1); 1 = kill on first overlapping frame.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse starting a scan
- clear_dead  in  1  clears all death flags and grace counters
- cfg_we  in  1  pool table write strobe
- cfg_idx  in  clog2(POOL_COUNT)  entry written
- cfg_x, cfg_y  in  COORD_W each  pool top-left, signed
- cfg_immune  in  PLAYER_COUNT  bit p set = player p immune to this pool
- cfg_en  in  1  entry enable
- player_top, player_bottom, player_left, player_right  in  PLAYER_COUNT*COORD_W each  packed signed boxes, player p at slice p
- player_dead  out  PLAYER_COUNT  sticky death flags
- killer_idx  out  PLAYER_COUNT*clog2(POOL_COUNT)  pool that killed player p
- scan_busy  out  1  high in SCAN and COMMIT
- frame_done  out  1  one-cycle pulse; dead/killer outputs valid for this frame

Behaviour:
- Reset (synchronous, active-high) clears:
  - FSM to IDLE;
  - all table entries (en=0, x=y=0, immune=0);
  - player_dead, killer_idx, grace counters, scan_busy and frame_done to 0.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE: on frame_tick, latch all player boxes, set scan index=0, clear per-player hit accumulators, go to SCAN. frame_tick is ignored while not in IDLE (no queuing).
- SCAN: each cycle evaluate entry[idx] for every player.
  - hit_p = en & ~immune[p] & right>x & left<x+POOL_W & bottom>y & top<y+POOL_H.
  - Comparisons are strict and signed. Sums are computed at COORD_W+1 bits, so there is no wrap.
  - On the first hit per player this scan, record idx as that player's candidate killer (lowest index wins).
  - When idx=POOL_COUNT-1, go to COMMIT; otherwise idx++.
- COMMIT (one cycle), per player not already dead:
  - If hit this scan: grace counter++. If the counter reaches GRACE_FRAMES, set player_dead and load killer_idx from the candidate.
  - If no hit: grace counter=0.
  - Then go to IDLE.
- frame_done pulses the cycle after COMMIT.
- Latency: frame_tick in cycle T gives SCAN in T+1..T+POOL_COUNT, COMMIT in T+POOL_COUNT+1, outputs and frame_done in T+POOL_COUNT+2.
- Dead players: player_dead is sticky until Reset or clear_dead. Grace counter and killer_idx are frozen while dead.
- clear_dead takes effect at the next edge and zeroes dead flags, killer_idx and grace counters. If it coincides with COMMIT, clear wins and that scan's hits are discarded. The FSM is otherwise unaffected.
- Config writes are accepted in any cycle and take effect at the next edge. If a write hits the entry being scanned in the same cycle, the scanner uses the old value.
- Reset mid-scan aborts the scan to IDLE with all state cleared.

Optional Feature:
- HAZARD_POOL_STATS_EN
- Defined: adds output death_count (PLAYER_COUNT*8), an 8-bit per-player counter.
  - Increments on each 0→1 transition of player_dead and saturates at 255.
  - Cleared only by Reset, not by clear_dead.
- Undefined: port and counters are absent.

Test Plan:
1. Pool0 = (302,463), en, immune=01; player0 box L300 R320 T450 B470; frame_tick → player_dead=00, frame_done at T+6 (POOL_COUNT=4).
2. Same setup, player1 at the same box → player_dead=10, killer_idx[1]=0.
3. Pools 1 = (430,463) and 3 = (398,360), immune=00; player0 overlapping both → player_dead[0]=1, killer_idx[0]=1.
4. Edge abut, player0 R=302 against pool x=302 → no death; R=303 → death.
5. GRACE_FRAMES=3: player0 overlaps frames 1,2, clears on 3, then overlaps 4,5,6 → dead only after frame 6's COMMIT. frame_tick during SCAN is ignored with no extra frame_done.
6. Player dead, then clear_dead asserted in the COMMIT cycle of an overlapping frame → player_dead=0 after that frame. The next overlapping frame sets it again. With HAZARD_POOL_STATS_EN, death_count=2.

Source files
------------

// File: rtl/hazard_pool_array.sv
// hazard_pool_array: runtime pool table scanned once per frame against latched player boxes, with grace counting and sticky death flags.
// Optional macro HAZARD_POOL_STATS_EN adds per-player saturating death counters.
module hazard_pool_array #(
  parameter int POOL_COUNT = 4,
  parameter int PLAYER_COUNT = 2,
  parameter int COORD_W = 16,
  parameter int POOL_W = 74,
  parameter int POOL_H = 5,
  parameter int GRACE_FRAMES = 1,
  localparam int IDX_W = POOL_COUNT > 1 ? $clog2(POOL_COUNT) : 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic frame_tick_i,
  input  logic clear_dead_i,
  input  logic cfg_we_i,
  input  logic [IDX_W-1:0] cfg_idx_i,
  input  logic [COORD_W-1:0] cfg_x_i,
  input  logic [COORD_W-1:0] cfg_y_i,
  input  logic [PLAYER_COUNT-1:0] cfg_immune_i,
  input  logic cfg_en_i,
  input  logic [PLAYER_COUNT*COORD_W-1:0] player_top_i,
  input  logic [PLAYER_COUNT*COORD_W-1:0] player_bottom_i,
  input  logic [PLAYER_COUNT*COORD_W-1:0] player_left_i,
  input  logic [PLAYER_COUNT*COORD_W-1:0] player_right_i,
  output logic [PLAYER_COUNT-1:0] player_dead_o,
  output logic [PLAYER_COUNT*IDX_W-1:0] killer_idx_o,
  output logic scan_busy_o,
  output logic frame_done_o
`ifdef HAZARD_POOL_STATS_EN
  ,
  output logic [PLAYER_COUNT*8-1:0] death_count_o
`endif
);
  localparam int GW = $clog2(GRACE_FRAMES + 1);
  localparam int SW = COORD_W + 1;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  typedef logic signed [SW-1:0] wide_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic frame_done_q;
  logic [POOL_COUNT-1:0] en_q;
  logic [COORD_W-1:0] px_q [POOL_COUNT];
  logic [COORD_W-1:0] py_q [POOL_COUNT];
  logic [PLAYER_COUNT-1:0] imm_q [POOL_COUNT];
  logic [COORD_W-1:0] top_q [PLAYER_COUNT];
  logic [COORD_W-1:0] bot_q [PLAYER_COUNT];
  logic [COORD_W-1:0] lft_q [PLAYER_COUNT];
  logic [COORD_W-1:0] rgt_q [PLAYER_COUNT];
  logic [PLAYER_COUNT-1:0] hit_q, hit_now, kill_now, dead_q;
  logic [IDX_W-1:0] cand_q [PLAYER_COUNT];
  logic [IDX_W-1:0] killer_q [PLAYER_COUNT];
  logic [GW-1:0] grace_q [PLAYER_COUNT];
  wide_t x_lo, x_hi, y_lo, y_hi;
  function automatic wide_t sx(input logic [COORD_W-1:0] v);
    return {v[COORD_W-1], v};
  endfunction
  // one extra bit of headroom keeps pool far edges from wrapping near the coordinate limits
  always_comb begin
    x_lo = sx(px_q[idx_q]);
    x_hi = x_lo + wide_t'(POOL_W);
    y_lo = sx(py_q[idx_q]);
    y_hi = y_lo + wide_t'(POOL_H);
    for (int p = 0; p < PLAYER_COUNT; p++) begin
      hit_now[p] = en_q[idx_q] & ~imm_q[idx_q][p] & (sx(rgt_q[p]) > x_lo) & (sx(lft_q[p]) < x_hi)
                 & (sx(bot_q[p]) > y_lo) & (sx(top_q[p]) < y_hi);
      kill_now[p] = (state_q == COMMIT) & ~clear_dead_i & ~dead_q[p] & hit_q[p]
                  & (grace_q[p] == GW'(GRACE_FRAMES - 1));
      killer_idx_o[p*IDX_W +: IDX_W] = killer_q[p];
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && frame_tick_i) state_d = SCAN;
    if (state_q == SCAN && idx_q == IDX_W'(POOL_COUNT - 1)) state_d = COMMIT;
    if (state_q == COMMIT) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      frame_done_q <= 1'b0;
      en_q <= '0;
      hit_q <= '0;
      dead_q <= '0;
      for (int i = 0; i < POOL_COUNT; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
        imm_q[i] <= '0;
      end
      for (int p = 0; p < PLAYER_COUNT; p++) begin
        top_q[p] <= '0;
        bot_q[p] <= '0;
        lft_q[p] <= '0;
        rgt_q[p] <= '0;
        cand_q[p] <= '0;
        killer_q[p] <= '0;
        grace_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      frame_done_q <= state_q == COMMIT;
      if (cfg_we_i && 32'(cfg_idx_i) < POOL_COUNT) begin
        en_q[cfg_idx_i] <= cfg_en_i;
        px_q[cfg_idx_i] <= cfg_x_i;
        py_q[cfg_idx_i] <= cfg_y_i;
        imm_q[cfg_idx_i] <= cfg_immune_i;
      end
      if (state_q == IDLE && frame_tick_i) begin
        idx_q <= '0;
        hit_q <= '0;
        for (int p = 0; p < PLAYER_COUNT; p++) begin
          top_q[p] <= player_top_i[p*COORD_W +: COORD_W];
          bot_q[p] <= player_bottom_i[p*COORD_W +: COORD_W];
          lft_q[p] <= player_left_i[p*COORD_W +: COORD_W];
          rgt_q[p] <= player_right_i[p*COORD_W +: COORD_W];
        end
      end
      if (state_q == SCAN) begin
        idx_q <= idx_q == IDX_W'(POOL_COUNT - 1) ? idx_q : idx_q + 1'b1;
        hit_q <= hit_q | hit_now;
        for (int p = 0; p < PLAYER_COUNT; p++)
          if (hit_now[p] && !hit_q[p]) cand_q[p] <= idx_q;
      end
      for (int p = 0; p < PLAYER_COUNT; p++) begin
        if (clear_dead_i) begin
          dead_q[p] <= 1'b0;
          killer_q[p] <= '0;
          grace_q[p] <= '0;
        end else if (state_q == COMMIT && !dead_q[p]) begin
          grace_q[p] <= hit_q[p] ? grace_q[p] + 1'b1 : '0;
          if (kill_now[p]) begin
            dead_q[p] <= 1'b1;
            killer_q[p] <= cand_q[p];
          end
        end
      end
    end
  end
  assign player_dead_o = dead_q;
  assign scan_busy_o = state_q != IDLE;
  assign frame_done_o = frame_done_q;
`ifdef HAZARD_POOL_STATS_EN
  logic [7:0] cnt_q [PLAYER_COUNT];
  always_ff @(posedge clk_i)
    for (int p = 0; p < PLAYER_COUNT; p++)
      if (reset_i) cnt_q[p] <= '0;
      else if (kill_now[p] && cnt_q[p] != 8'hFF) cnt_q[p] <= cnt_q[p] + 8'd1;
  always_comb
    for (int p = 0; p < PLAYER_COUNT; p++) death_count_o[p*8 +: 8] = cnt_q[p];
`endif
endmodule

// File: tb/tb_hazard_pool_array.sv
// tb_hazard_pool_array: directed frames against a grace-1 and a grace-3 instance sharing all inputs.
module tb_hazard_pool_array;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, tick = 1'b0, clr = 1'b0, we = 1'b0, cen = 1'b0;
  logic [1:0] cidx = '0, cimm = '0;
  logic [15:0] cx = '0, cy = '0;
  logic [31:0] ptop = '0, pbot = '0, plft = '0, prgt = '0;
  logic [1:0] dead_a, dead_b;
  logic [3:0] kill_a, kill_b;
  logic busy_a, busy_b, fd_a, fd_b;
`ifdef HAZARD_POOL_STATS_EN
  logic [15:0] dc_a, dc_b;
`endif
  hazard_pool_array dut_a (
    .clk_i(clk), .reset_i(reset), .frame_tick_i(tick), .clear_dead_i(clr),
    .cfg_we_i(we), .cfg_idx_i(cidx), .cfg_x_i(cx), .cfg_y_i(cy), .cfg_immune_i(cimm), .cfg_en_i(cen),
    .player_top_i(ptop), .player_bottom_i(pbot), .player_left_i(plft), .player_right_i(prgt),
    .player_dead_o(dead_a), .killer_idx_o(kill_a), .scan_busy_o(busy_a), .frame_done_o(fd_a)
`ifdef HAZARD_POOL_STATS_EN
    , .death_count_o(dc_a)
`endif
  );
  hazard_pool_array #(.GRACE_FRAMES(3)) dut_b (
    .clk_i(clk), .reset_i(reset), .frame_tick_i(tick), .clear_dead_i(clr),
    .cfg_we_i(we), .cfg_idx_i(cidx), .cfg_x_i(cx), .cfg_y_i(cy), .cfg_immune_i(cimm), .cfg_en_i(cen),
    .player_top_i(ptop), .player_bottom_i(pbot), .player_left_i(plft), .player_right_i(prgt),
    .player_dead_o(dead_b), .killer_idx_o(kill_b), .scan_busy_o(busy_b), .frame_done_o(fd_b)
`ifdef HAZARD_POOL_STATS_EN
    , .death_count_o(dc_b)
`endif
  );
  typedef struct packed {logic [1:0] da; logic [3:0] ka; logic [1:0] db; logic [3:0] kb;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [1:0] i, input int x, input int y, input logic [1:0] im, input logic e);
    @(negedge clk);
    we = 1'b1; cidx = i; cx = 16'(x); cy = 16'(y); cimm = im; cen = e;
    @(negedge clk);
    we = 1'b0;
  endtask
  task automatic setp(input int p, input int l, input int r, input int t, input int b);
    plft[p*16 +: 16] = 16'(l);
    prgt[p*16 +: 16] = 16'(r);
    ptop[p*16 +: 16] = 16'(t);
    pbot[p*16 +: 16] = 16'(b);
  endtask
  task automatic park(input int p);
    setp(p, 1000, 1010, 0, 10);
  endtask
  task automatic pulse_clear;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask
  task automatic quiet(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen = seen | fd_a | fd_b | busy_a | busy_b;
    end
    chk(tag, seen, 0);
  endtask
  // re_tick/clr_at: negedge count after the tick at which to pulse frame_tick or clear_dead again
  task automatic frame(input string tag, input logic [1:0] da, input logic [3:0] ka,
                       input logic [1:0] db, input logic [3:0] kb, input int re_tick, input int clr_at);
    exp_t e;
    int n = 0;
    @(negedge clk);
    tick = 1'b1;
    sb.push_back({da, ka, db, kb});
    while (n < 20) begin
      @(negedge clk);
      n++;
      tick = n == re_tick;
      clr = n == clr_at;
      if (n == 1) chk({tag, " busy"}, {busy_a, busy_b}, 2'b11);
      if (fd_a) break;
    end
    tick = 1'b0;
    clr = 1'b0;
    chk({tag, " latency"}, n, 6);
    chk({tag, " done_b"}, fd_b, 1);
    e = sb.pop_front();
    chk({tag, " dead_a"}, dead_a, e.da);
    chk({tag, " killer_a"}, kill_a, e.ka);
    chk({tag, " dead_b"}, dead_b, e.db);
    chk({tag, " killer_b"}, kill_b, e.kb);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst dead", {dead_a, dead_b}, 0);
    chk("rst killer", {kill_a, kill_b}, 0);
    chk("rst busy", {busy_a, busy_b}, 0);
    chk("rst done", {fd_a, fd_b}, 0);
    setp(0, 300, 320, 450, 470);
    park(1);
    wr(0, 302, 463, 2'b01, 1'b1);
    frame("immune", 2'b00, 4'b0000, 2'b00, 4'b0000, 0, 0);
    setp(1, 300, 320, 450, 470);
    frame("p1hit", 2'b10, 4'b0000, 2'b00, 4'b0000, 0, 0);
    pulse_clear;
    wr(1, 430, 463, 2'b00, 1'b1);
    wr(3, 398, 360, 2'b00, 1'b1);
    setp(0, 440, 460, 350, 470);
    park(1);
    frame("lowest", 2'b01, 4'b0001, 2'b00, 4'b0000, 0, 0);
    park(0);
    frame("sticky", 2'b01, 4'b0001, 2'b00, 4'b0000, 0, 0);
    pulse_clear;
    wr(1, 430, 463, 2'b00, 1'b0);
    wr(3, 398, 360, 2'b00, 1'b0);
    wr(2, 302, 463, 2'b00, 1'b1);
    setp(0, 280, 302, 450, 470);
    setp(1, 376, 400, 450, 470);
    frame("abut", 2'b00, 4'b0000, 2'b00, 4'b0000, 0, 0);
    setp(0, 280, 303, 450, 470);
    setp(1, 375, 400, 450, 470);
    frame("touch", 2'b11, 4'b0010, 2'b00, 4'b0000, 0, 0);
    pulse_clear;
    park(1);
    frame("g1", 2'b01, 4'b0010, 2'b00, 4'b0000, 0, 0);
    frame("g2", 2'b01, 4'b0010, 2'b00, 4'b0000, 0, 0);
    park(0);
    frame("g3", 2'b01, 4'b0010, 2'b00, 4'b0000, 0, 0);
    setp(0, 280, 303, 450, 470);
    frame("g4", 2'b01, 4'b0010, 2'b00, 4'b0000, 2, 0);
    quiet("no extra frame", 8);
    frame("g5", 2'b01, 4'b0010, 2'b00, 4'b0000, 0, 0);
    frame("g6", 2'b01, 4'b0010, 2'b01, 4'b0010, 0, 0);
    frame("clr_commit", 2'b00, 4'b0000, 2'b00, 4'b0000, 0, 5);
    frame("redie", 2'b01, 4'b0010, 2'b00, 4'b0000, 0, 0);
`ifdef HAZARD_POOL_STATS_EN
    chk("count_a", dc_a, 16'h0204);
    chk("count_b", dc_b, 16'h0001);
`endif
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort busy", {busy_a, busy_b}, 0);
    chk("abort dead", {dead_a, dead_b}, 0);
    quiet("abort quiet", 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
